// File: rtl/reg_file_pkg.sv
// Shared constants for the architectural register file: ROB tag width, register count, zero-register index.
package reg_file_pkg;

    localparam int DEF_ROB_WIDTH_BIT = 5;
    localparam int DEF_REG_NUM_BIT   = 5;
    localparam int REG_NUM           = 1 << DEF_REG_NUM_BIT;
    localparam int XLEN              = 32;
    localparam logic [DEF_REG_NUM_BIT-1:0] ZERO_REG = 5'd0;

    // True for any register that can hold state (everything except x0).
    function automatic logic is_arch_reg(input logic [DEF_REG_NUM_BIT-1:0] id);
        return (id != ZERO_REG);
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One source-operand resolver (module reg_read_port): zero reg, committed value, or ROB forward.
// Optional same-cycle commit bypass under REGFILE_BYPASS_EN.
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int ROB_WIDTH_BIT = DEF_ROB_WIDTH_BIT
) (
    input  logic [DEF_REG_NUM_BIT-1:0] rs_id,
    input  logic                       reg_busy,
    input  logic [XLEN-1:0]            reg_value,
    input  logic [ROB_WIDTH_BIT-1:0]   reg_tag,
    input  logic                       rob_ready,
    input  logic [XLEN-1:0]            rob_val,
`ifdef REGFILE_BYPASS_EN
    input  logic                       clear_flag,
    input  logic [DEF_REG_NUM_BIT-1:0] cmt_reg_id,
    input  logic [XLEN-1:0]            cmt_val,
    input  logic [ROB_WIDTH_BIT-1:0]   cmt_rob_id,
`endif
    output logic                       ready,
    output logic [XLEN-1:0]            val,
    output logic [ROB_WIDTH_BIT-1:0]   tag,
    output logic [ROB_WIDTH_BIT-1:0]   rob_id
);

    logic                     ready_s;
    logic [XLEN-1:0]          val_s;
    logic [ROB_WIDTH_BIT-1:0] tag_s;

    // Tag of an idle register is held at zero, so the query id is the raw tag.
    assign rob_id = reg_tag;
    assign ready  = ready_s;
    assign val    = val_s;
    assign tag    = tag_s;

    // Operand resolution: zero register, then committed value, then ROB answer.
    always_comb begin
        ready_s = 1'b1;
        val_s   = 32'h0000_0000;
        tag_s   = '0;
        if (!is_arch_reg(rs_id)) begin
            ready_s = 1'b1;
        end else if (!reg_busy) begin
            val_s = reg_value;
        end else begin
            ready_s = rob_ready;
            val_s   = rob_ready ? rob_val : 32'h0000_0000;
            tag_s   = reg_tag;
        end
`ifdef REGFILE_BYPASS_EN
        if (is_arch_reg(rs_id) && (rs_id == cmt_reg_id) && !clear_flag &&
            (!reg_busy || (reg_tag == cmt_rob_id))) begin
            ready_s = 1'b1;
            val_s   = cmt_val;
            tag_s   = '0;
        end else begin
            ready_s = ready_s;
        end
`endif
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with ROB rename tags; flush > rename > commit on each ready edge.
// Optional same-cycle commit-to-read bypass when REGFILE_BYPASS_EN is defined.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int ROB_WIDTH_BIT = DEF_ROB_WIDTH_BIT,
    parameter int REG_NUM_BIT   = DEF_REG_NUM_BIT
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_flag,
    input  logic [REG_NUM_BIT-1:0]   cmt_reg_id,
    input  logic [XLEN-1:0]          cmt_val,
    input  logic [ROB_WIDTH_BIT-1:0] cmt_rob_id,
    input  logic [REG_NUM_BIT-1:0]   ren_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] ren_rob_id,
    input  logic [REG_NUM_BIT-1:0]   dec_rs1_id,
    input  logic [REG_NUM_BIT-1:0]   dec_rs2_id,
    output logic                     dec_rs1_ready,
    output logic                     dec_rs2_ready,
    output logic [XLEN-1:0]          dec_rs1_val,
    output logic [XLEN-1:0]          dec_rs2_val,
    output logic [ROB_WIDTH_BIT-1:0] dec_rs1_tag,
    output logic [ROB_WIDTH_BIT-1:0] dec_rs2_tag,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
    input  logic                     rob_rs1_ready,
    input  logic                     rob_rs2_ready,
    input  logic [XLEN-1:0]          rob_rs1_val,
    input  logic [XLEN-1:0]          rob_rs2_val
);

    localparam int NREG = 1 << REG_NUM_BIT;

    logic [XLEN-1:0]          value_r [NREG];
    logic [ROB_WIDTH_BIT-1:0] tag_r   [NREG];
    logic [NREG-1:0]          busy_r;

    // Register state update; x0 is never touched after reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_r <= '0;
            for (int i = 0; i < NREG; i++) begin
                value_r[i] <= 32'h0000_0000;
                tag_r[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (clear_flag) begin
                busy_r <= '0;
                for (int i = 0; i < NREG; i++) begin
                    tag_r[i] <= '0;
                end
            end else begin
                for (int i = 1; i < NREG; i++) begin
                    if (cmt_reg_id == REG_NUM_BIT'(i)) begin
                        value_r[i] <= cmt_val;
                        // Only the producer currently mapped may release the register.
                        if (busy_r[i] && (tag_r[i] == cmt_rob_id)) begin
                            busy_r[i] <= 1'b0;
                            tag_r[i]  <= '0;
                        end
                    end
                    if (ren_reg_id == REG_NUM_BIT'(i)) begin
                        busy_r[i] <= 1'b1;
                        tag_r[i]  <= ren_rob_id;
                    end
                end
            end
        end
    end

    reg_read_port #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT)) u_rs1 (
        .rs_id      (dec_rs1_id),
        .reg_busy   (busy_r[dec_rs1_id]),
        .reg_value  (value_r[dec_rs1_id]),
        .reg_tag    (tag_r[dec_rs1_id]),
        .rob_ready  (rob_rs1_ready),
        .rob_val    (rob_rs1_val),
`ifdef REGFILE_BYPASS_EN
        .clear_flag (clear_flag),
        .cmt_reg_id (cmt_reg_id),
        .cmt_val    (cmt_val),
        .cmt_rob_id (cmt_rob_id),
`endif
        .ready      (dec_rs1_ready),
        .val        (dec_rs1_val),
        .tag        (dec_rs1_tag),
        .rob_id     (rob_rs1_id)
    );

    reg_read_port #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT)) u_rs2 (
        .rs_id      (dec_rs2_id),
        .reg_busy   (busy_r[dec_rs2_id]),
        .reg_value  (value_r[dec_rs2_id]),
        .reg_tag    (tag_r[dec_rs2_id]),
        .rob_ready  (rob_rs2_ready),
        .rob_val    (rob_rs2_val),
`ifdef REGFILE_BYPASS_EN
        .clear_flag (clear_flag),
        .cmt_reg_id (cmt_reg_id),
        .cmt_val    (cmt_val),
        .cmt_rob_id (cmt_rob_id),
`endif
        .ready      (dec_rs2_ready),
        .val        (dec_rs2_val),
        .tag        (dec_rs2_tag),
        .rob_id     (rob_rs2_id)
    );

endmodule
